// File: rtl/stack_binop_seq_if.sv
// Command and operand-stack signal bundle for stack_binop_seq.
// Commands use valid/ready: a command transfers on a rising edge where in_valid && in_ready; out_valid is a one-cycle completion pulse with no back-pressure.
interface stack_binop_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic             out_valid;
    logic [1:0]       out_error;
    logic [1:0]       stk_op;
    logic [WIDTH-1:0] stk_data;
    logic [WIDTH-1:0] stk_tos;
    logic [1:0]       stk_status;
    logic [1:0]       stk_error;

    modport slave (
        input  in_valid, in_opcode, stk_tos, stk_status, stk_error,
        output in_ready, out_valid, out_error, stk_op, stk_data
    );

    modport master (
        output in_valid, in_opcode, stk_tos, stk_status, stk_error,
        input  in_ready, out_valid, out_error, stk_op, stk_data
    );
endinterface

// File: rtl/stack_binop_seq.sv
// Pops b, reads a, and replaces the new top of the operand stack with (a op b).
// Stack faults and early underflow are reported with the one-cycle completion pulse.
module stack_binop_seq #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    stack_binop_seq_if.slave  bus,
    output logic [2:0]        o_dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_POP     = 3'd1;
    localparam logic [2:0] S_FETCH_A = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       r_state;
    logic [3:0]       r_opcode;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_err;
    logic             r_wrote;

    logic [WIDTH-1:0] w_a;
    logic [SHW-1:0]   w_s;
    logic [SHW:0]     w_rs;
    logic [WIDTH-1:0] w_result;

    // Operand a is live on stk_tos during FETCH_A and held in r_a afterwards.
    always_comb begin
        w_a      = (r_state == S_FETCH_A) ? bus.stk_tos : r_a;
        w_s      = r_b[SHW-1:0];
        w_rs     = (SHW+1)'(WIDTH) - {1'b0, w_s};
        w_result = '0;
        case (r_opcode)
            4'd0:  w_result = w_a + r_b;
            4'd1:  w_result = w_a - r_b;
            4'd2:  w_result = w_a * r_b;
            4'd3:  w_result = w_a & r_b;
            4'd4:  w_result = w_a | r_b;
            4'd5:  w_result = w_a ^ r_b;
            4'd6:  w_result = w_a << w_s;
            4'd7:  w_result = w_a >> w_s;
            4'd8:  w_result = WIDTH'($signed(w_a) >>> w_s);
            4'd9:  w_result = (w_a << w_s) | (w_a >> w_rs);
            4'd10: w_result = (w_a >> w_s) | (w_a << w_rs);
            4'd11: w_result = {{(WIDTH-1){1'b0}}, (w_a == r_b)};
            4'd12: w_result = {{(WIDTH-1){1'b0}}, (w_a != r_b)};
            4'd13: w_result = {{(WIDTH-1){1'b0}}, (w_a < r_b)};
            4'd14: w_result = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(r_b))};
            default: w_result = {{(WIDTH-1){1'b0}}, (w_a >= r_b)};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_err    <= '0;
            r_wrote  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_opcode <= bus.in_opcode;
                        r_b      <= bus.stk_tos;
                        r_wrote  <= 1'b0;
                        if (bus.stk_status == 2'd1) begin
                            r_err   <= 2'd1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 2'd0;
                            r_state <= S_POP;
                        end
                    end
                end
                S_POP: r_state <= S_FETCH_A;
                S_FETCH_A: begin
                    if (bus.stk_error != 2'd0) begin
                        r_err   <= bus.stk_error;
                        r_state <= S_DONE;
                    end else if (bus.stk_status == 2'd1) begin
                        // b stays consumed: the trap leaves the stack one shorter.
                        r_err   <= 2'd1;
                        r_state <= S_DONE;
                    end else begin
                        r_a      <= bus.stk_tos;
                        r_result <= w_result;
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_wrote <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.out_error = 2'd0;
        bus.stk_op    = 2'd0;
        bus.stk_data  = '0;
        case (r_state)
            S_POP:   bus.stk_op = 2'd2;
            S_WRITE: begin
                bus.stk_op   = 2'd3;
                bus.stk_data = r_result;
            end
            S_DONE:  bus.out_error = (r_err != 2'd0) ? r_err : (r_wrote ? bus.stk_error : 2'd0);
            default: ;
        endcase
    end

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_stack_binop_seq.sv
// Bench for stack_binop_seq: a behavioural operand stack plus a queue-based reference of the command semantics.
module tb_stack_binop_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] dbg_state;

    stack_binop_seq_if #(.WIDTH(8)) bus ();

    stack_binop_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- environment: operand stack ----------------
    logic [7:0] mem [0:7];
    int         sk_depth = 0;
    logic [1:0] sk_err = 2'd0;
    logic       tb_clear = 1'b0;
    logic       tb_push = 1'b0;
    logic [7:0] tb_push_data = 8'd0;
    logic       tb_force_err = 1'b0;

    always_comb begin
        bus.stk_tos    = (sk_depth > 0) ? mem[sk_depth-1] : 8'd0;
        bus.stk_status = (sk_depth == 0) ? 2'd1 : ((sk_depth == 8) ? 2'd2 : 2'd0);
        bus.stk_error  = sk_err;
    end

    always @(posedge clk) begin
        if (tb_clear) begin
            sk_depth <= 0;
            sk_err   <= 2'd0;
        end else if (tb_push) begin
            if (sk_depth < 8) begin
                mem[sk_depth] <= tb_push_data;
                sk_depth      <= sk_depth + 1;
            end
        end else begin
            case (bus.stk_op)
                2'd2: if (sk_depth == 0) sk_err <= 2'd1;
                      else begin
                          sk_depth <= sk_depth - 1;
                          sk_err   <= tb_force_err ? 2'd2 : 2'd0;
                      end
                2'd3: if (sk_depth == 0) sk_err <= 2'd1;
                      else begin
                          mem[sk_depth-1] <= bus.stk_data;
                          sk_err          <= 2'd0;
                      end
                default: sk_err <= 2'd0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input int op, input int a, input int b);
        int s, sa, sb, r;
        s  = b % 8;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a * b;
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = a * (1 << s);
            7:  r = a / (1 << s);
            8:  r = sa >>> s;
            9:  r = (a << s) | (a >> (8 - s));
            10: r = (a >> s) | (a << (8 - s));
            11: r = (a == b) ? 1 : 0;
            12: r = (a != b) ? 1 : 0;
            13: r = (a < b) ? 1 : 0;
            14: r = (sa < sb) ? 1 : 0;
            default: r = (a >= b) ? 1 : 0;
        endcase
        return 8'(r);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_stack();
        @(negedge clk); tb_clear = 1'b1;
        @(negedge clk); tb_clear = 1'b0;
        model_q.delete();
    endtask

    task automatic push_val(input logic [7:0] v);
        @(negedge clk); tb_push = 1'b1; tb_push_data = v;
        @(negedge clk); tb_push = 1'b0;
        model_q.push_back(v);
    endtask

    task automatic check_stack(input string tag);
        check_eq({tag, "_depth"}, 32'(sk_depth), 32'(model_q.size()));
        if (model_q.size() > 0) check_eq({tag, "_top"}, 32'(bus.stk_tos), 32'(model_q[$]));
    endtask

    task automatic run_cmd(input int op, input bit hold);
        logic [7:0] a, b;
        logic [1:0] eerr, eop;
        int         lat;
        eerr = 2'd0;
        if (model_q.size() == 0) begin
            lat = 1; eerr = 2'd1;
        end else begin
            b = model_q.pop_back();
            if (tb_force_err) begin
                lat = 3; eerr = 2'd2;
            end else if (model_q.size() == 0) begin
                lat = 3; eerr = 2'd1;
            end else begin
                a = model_q.pop_back();
                model_q.push_back(ref_op(op, a, b));
                exp_q.push_back(model_q[$]);
                lat = 4;
            end
        end
        @(negedge clk);
        check_eq("idle_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.in_opcode = 4'(op);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            eop = (k == 1 && lat > 1) ? 2'd2 : ((k == 3 && lat == 4) ? 2'd3 : 2'd0);
            check_eq("stk_op", 32'(bus.stk_op), 32'(eop));
            if (eop == 2'd3) check_eq("stk_data", 32'(bus.stk_data), 32'(exp_q.pop_front()));
            if (eop == 2'd2) check_eq("pop_data", 32'(bus.stk_data), 32'd0);
            check_eq("out_valid", 32'(bus.out_valid), (k == lat) ? 32'd1 : 32'd0);
            if (k == lat) check_eq("out_error", 32'(bus.out_error), 32'(eerr));
            if (!hold || k == lat) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("ready_after", 32'(bus.in_ready), 32'd1);
        check_eq("no_extra_valid", 32'(bus.out_valid), 32'd0);
        check_stack("post_cmd");
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] shift_exp [0:4];
    logic [7:0] cmp_exp   [0:4];
    int         cmp_ops   [0:4];

    initial begin
        shift_exp[0] = 8'h02; shift_exp[1] = 8'h40; shift_exp[2] = 8'hC0;
        shift_exp[3] = 8'h03; shift_exp[4] = 8'hC0;
        cmp_ops[0] = 13; cmp_ops[1] = 14; cmp_ops[2] = 15; cmp_ops[3] = 11; cmp_ops[4] = 12;
        cmp_exp[0] = 8'd0; cmp_exp[1] = 8'd1; cmp_exp[2] = 8'd1; cmp_exp[3] = 8'd0; cmp_exp[4] = 8'd1;
        bus.in_valid = 1'b0; bus.in_opcode = 4'd0;

        #1;
        check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_error", 32'(bus.out_error), 32'd0);
        check_eq("rst_op", 32'(bus.stk_op), 32'd0);
        check_eq("rst_data", 32'(bus.stk_data), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_stack();

        push_val(8'd3); push_val(8'd5);
        run_cmd(1, 1'b0);
        check_eq("sub_top", 32'(bus.stk_tos), 32'hFE);
        check_eq("sub_depth", 32'(sk_depth), 32'd1);

        clear_stack();
        run_cmd(0, 1'b0);

        push_val(8'd7);
        run_cmd(0, 1'b0);
        check_eq("one_elem_depth", 32'(sk_depth), 32'd0);

        for (int i = 0; i < 5; i++) begin
            clear_stack(); push_val(8'h81); push_val(8'h09);
            run_cmd(6 + i, 1'b0);
            check_eq("shift_tbl", 32'(bus.stk_tos), 32'(shift_exp[i]));
        end
        for (int i = 0; i < 5; i++) begin
            clear_stack(); push_val(8'hFF); push_val(8'h01);
            run_cmd(cmp_ops[i], 1'b0);
            check_eq("cmp_tbl", 32'(bus.stk_tos), 32'(cmp_exp[i]));
        end
        clear_stack(); push_val(8'h10); push_val(8'h11);
        run_cmd(2, 1'b0);
        check_eq("mul_top", 32'(bus.stk_tos), 32'h10);

        clear_stack(); push_val(8'd1); push_val(8'd2); push_val(8'd3);
        run_cmd(0, 1'b1);
        run_cmd(0, 1'b1);
        check_eq("b2b_top", 32'(bus.stk_tos), 32'd6);
        check_eq("b2b_depth", 32'(sk_depth), 32'd1);

        clear_stack(); push_val(8'd4); push_val(8'd9);
        tb_force_err = 1'b1;
        run_cmd(0, 1'b0);
        tb_force_err = 1'b0;

        // Reset while the replace is on the bus: command abandoned, pop kept.
        clear_stack(); push_val(8'd3); push_val(8'd5);
        @(negedge clk); bus.in_valid = 1'b1; bus.in_opcode = 4'd1;
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_write", 32'(bus.stk_op), 32'd3);
        reset = 1'b0;
        #1;
        check_eq("midrst_op", 32'(bus.stk_op), 32'd0);
        check_eq("midrst_data", 32'(bus.stk_data), 32'd0);
        check_eq("midrst_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);
        void'(model_q.pop_back());
        void'(exp_q.pop_front());
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("postrst_valid", 32'(bus.out_valid), 32'd0);
        end
        check_stack("postrst");

        for (int t = 0; t < 40; t++) begin
            clear_stack();
            for (int j = $urandom_range(0, 4); j > 0; j--) push_val(8'($urandom_range(0, 255)));
            run_cmd($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0 && model_q.size() >= 1) begin
                push_val(8'($urandom_range(0, 255)));
                run_cmd($urandom_range(0, 15), 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/stack_binop_seq.md
Name: stack_binop_seq

Overview:
- Sequencer directly upstream of the CPU operand stack; executes one WASM-style binary integer operation per accepted command.
- Per command: reads operand b from top of stack, pops it, reads operand a, then replaces the new top with (a op b).
- Drives the stack's op/data inputs and consumes its tos/status/error outputs.
- Reports completion and any stack fault to the issuing control unit.

Parameters:
WIDTH, 8, operand/stack data width in bits; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount bits used from b (derived, not overridden)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  command present
in_ready  output  1  sequencer can accept a command; high only in IDLE
in_opcode  input  4  operation select, sampled on accept
out_valid  output  1  one-cycle pulse when the command completes
out_error  output  2  completion status, valid with out_valid: 0 none, 1 underflow, 2 overflow
stk_op  output  2  to stack: 0 none, 1 push, 2 pop, 3 replace
stk_data  output  WIDTH  to stack: data for replace; 0 during pop, so exactly one frame is popped
stk_tos  input  WIDTH  from stack: current top of stack, combinational from stack index
stk_status  input  2  from stack: 0 none, 1 empty, 2 full
stk_error  input  2  from stack: registered error of previous op: 0 none, 1 underflow, 2 overflow

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; a, b, result, opcode registers cleared.
  - out_valid=0, out_error=0, stk_op=0, stk_data=0, in_ready=1.
  - Asserting reset mid-command abandons the command; any pop already performed is not undone; no out_valid is produced.
- States: IDLE, POP, FETCH_A, WRITE, DONE.
- stk_op and stk_data are combinational from state:
  - POP: stk_op=2, stk_data=0.
  - WRITE: stk_op=3, stk_data=result.
  - All other states: 0.
- IDLE: in_ready=1. On in_valid at edge T0:
  - Latch opcode and b=stk_tos.
  - If stk_status==1 (empty), go to DONE with err=1 and issue no stack op.
  - Otherwise go to POP.
- POP (T1): stack removes b at the end of this cycle. Go to FETCH_A.
- FETCH_A (T2): stk_tos/stk_status/stk_error now reflect the post-pop stack.
  - If stk_error!=0, go to DONE with err=stk_error.
  - Else if stk_status==1 (a missing), go to DONE with err=1. b remains consumed (trap semantics).
  - Else latch a=stk_tos, register result=f(opcode,a,b), go to WRITE.
- WRITE (T3): replace issued. Go to DONE.
- DONE: out_valid=1 for exactly one cycle. out_error = latched err, or stk_error if a replace error is visible. Then return to IDLE.
- Latency: nominal command is accept at T0, out_valid at T4, so next accept at T5 at the earliest. Early empty underflow gives out_valid at T1.
- Opcodes: all arithmetic is modulo 2^WIDTH; "signed" means two's complement.
  - 0 ADD a+b; 1 SUB a-b; 2 MUL low WIDTH bits.
  - 3 AND; 4 OR; 5 XOR.
  - 6 SHL a<<s; 7 SHR_U logical; 8 SHR_S arithmetic; 9 ROTL; 10 ROTR. For shifts and rotates, s=b[SHW-1:0].
  - 11 EQ; 12 NE; 13 LT_U; 14 LT_S; 15 GE_U. Comparisons give 1 if true else 0, zero-extended.
- Net stack effect of a successful command: depth -1 and new top = result.
- in_valid while in_ready=0 is ignored; the command is neither queued nor latched.
- Overflow cannot originate from this block (no push), but a nonzero stk_error from the stack is passed through.

Test Plan:
- Stack [3,5] (5 on top), opcode 1 SUB -> stk_op sequence 2,0,3 at T1..T3; stk_data=0xFE at T3; out_valid at T4, out_error=0; stack then holds [0xFE], depth 1.
- Stack empty, opcode 0 -> no stack op; out_valid at T1 with out_error=1; in_ready high at T2.
- Stack [7] only, opcode 0 -> pop at T1; FETCH_A sees empty; out_valid at T3 with out_error=1; no replace; stack empty.
- WIDTH=8, a=0x81, b=0x09 (shift amount 1): SHL->0x02, SHR_U->0x40, SHR_S->0xC0, ROTL->0x03, ROTR->0xC0.
- a=0xFF, b=0x01: LT_U->0, LT_S->1, GE_U->1, EQ->0, NE->1; MUL a=0x10, b=0x11 -> 0x10.
- Reset low during WRITE -> outputs 0 and in_ready=1 immediately, no out_valid. Also: in_valid held high through a command -> exactly one command per IDLE visit; back-to-back commands on stack [1,2,3] with ADD, ADD -> final top 6, depth 1.
